// File: rtl/mul_pkg.sv
// Shared definitions for the sequential RISC-V M-extension multiplier:
// op encodings, sequencer states and the partial-product count.
package mul_pkg;

  localparam int NUM_PP = 17;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/booth_radix4_multiplier.sv
// Combinational radix-4 Booth partial-product generator: 17 x 64-bit terms whose
// modulo-2^64 sum is a*b (signed x signed when alu_signed, else unsigned x unsigned).
module booth_radix4_multiplier
  import mul_pkg::*;
(
  input  logic [31:0]                  a,
  input  logic [31:0]                  b,
  input  logic                         alu_signed,
  output logic [NUM_PP-1:0][63:0]      pp
);

  logic [63:0] a_ext;
  logic [34:0] b_ext;
  logic [63:0] mult;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    a_ext = alu_signed ? {{32{a[31]}}, a} : {32'h0, a};
    // b is widened to 34 bits so the top Booth digit sees the true sign; bit 0 is the implicit b[-1].
    b_ext = {(alu_signed ? {2{b[31]}} : 2'b00), b, 1'b0};
    mult  = '0;
    pp    = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      unique case (b_ext[2*i +: 3])
        3'b001, 3'b010: mult = a_ext;
        3'b011:         mult = a_ext << 1;
        3'b100:         mult = -(a_ext << 1);
        3'b101, 3'b110: mult = -a_ext;
        default:        mult = '0;
      endcase
      pp[i] = mult << (2 * i);
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle sequencer around the Booth PP generator: accepts a multiply request,
// accumulates PP_PER_CYCLE partial products per clock and returns one 32-bit word.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int PP_PER_CYCLE = 4,
  parameter int TAG_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NCYC  = (NUM_PP + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
  localparam int IDX_W = $clog2(NUM_PP + PP_PER_CYCLE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((NCYC - 1) * PP_PER_CYCLE);
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(PP_PER_CYCLE);

  state_e                  state, state_next;
  logic [31:0]             a_q, b_q;
  mul_op_e                 op_q;
  logic [TAG_W-1:0]        tag_q;
  logic [63:0]             acc, acc_next, pp_sum;
  logic [IDX_W-1:0]        idx;
  logic [NUM_PP-1:0][63:0] pp;
  logic                    accept, last_cyc;

  booth_radix4_multiplier u_booth (
    .a          (a_q),
    .b          (b_q),
    .alu_signed (op_q == MUL_OP_MULH),
    .pp         (pp)
  );

  assign last_cyc  = (state == ACC) && (idx == LAST_IDX);
  assign out_valid = (state == DONE);

  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    // A flush cycle never accepts, so abort and accept cannot collide.
    if (rst || flush) in_ready = 1'b0;
    accept = in_valid && in_ready;

    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = ACC;
      ACC:     if (last_cyc) state_next = DONE;
      DONE:    if (out_ready) state_next = accept ? ACC : IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_comb begin
    pp_sum = '0;
    for (int j = 0; j < NUM_PP; j++) begin
      if (j >= int'(idx) && j < int'(idx) + PP_PER_CYCLE) pp_sum = pp_sum + pp[j];
    end
    acc_next = acc + pp_sum;
    // The generator ran unsigned x unsigned; removing b*2^32 makes a's top bit weigh -2^31.
    if (last_cyc && op_q == MUL_OP_MULHSU && a_q[31]) acc_next = acc_next - {b_q, 32'h0};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= MUL_OP_MUL;
      tag_q      <= '0;
      acc        <= '0;
      idx        <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (accept) begin
      a_q   <= in_a;
      b_q   <= in_b;
      op_q  <= mul_op_e'(in_op);
      tag_q <= in_tag;
      acc   <= '0;
      idx   <= '0;
    end else if (state == ACC && !flush) begin
      acc <= acc_next;
      idx <= idx + IDX_STEP;
      if (last_cyc) begin
        out_result <= (op_q == MUL_OP_MUL) ? acc_next[31:0] : acc_next[63:32];
        out_tag    <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed corner cases, handshake/flush/reset
// scenarios and randomized ops against a plain-arithmetic reference model.
module tb_mul_seq_ctrl;

  localparam int TAG_W = 5;
  localparam int LAT   = (17 + 4 - 1) / 4 + 1;
  localparam logic [1:0] OP_MUL = 2'b00, OP_MULH = 2'b01, OP_MULHSU = 2'b10, OP_MULHU = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = '0;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  mul_seq_ctrl #(.PP_PER_CYCLE(4), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (op)
      OP_MUL:    p = ua * ub;
      OP_MULH:   p = sa * sb;
      OP_MULHSU: p = sa * ub;
      default:   p = ua * ub;
    endcase
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag);
    int n;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("accept_wait", 64'(n < 50), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int lat;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk); lat++;
    end
    check(tag, 64'(lat), 64'(LAT));
  endtask

  task automatic finish_op(input int hold, input logic [31:0] exp_res, input logic [TAG_W-1:0] exp_tag);
    for (int h = 0; h < hold; h++) begin
      #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_ready", 64'(in_ready), 64'd0);
      check("hold_result", 64'(out_result), 64'(exp_res));
      check("hold_tag", 64'(out_tag), 64'(exp_tag));
      @(negedge clk);
    end
    check("result", 64'(out_result), 64'(exp_res));
    check("tag", 64'(out_tag), 64'(exp_tag));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", 64'(out_valid), 64'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input int hold, input logic [31:0] exp_res);
    start_op(op, a, b, tag);
    wait_result("latency");
    finish_op(hold, exp_res, tag);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0]       r_op;
    logic [31:0]      r_a, r_b;
    logic [TAG_W-1:0] r_tag;

    // Reset values
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Directed corner cases
    run_op(OP_MUL,    32'h0000_0003, 32'h0000_0005, 5'd7,  0, 32'h0000_000F);
    run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1,  0, 32'h4000_0000);
    run_op(OP_MULH,   32'h8000_0000, 32'h0000_0001, 5'd2,  1, 32'hFFFF_FFFF);
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  0, 32'hFFFF_FFFE);
    run_op(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  0, 32'h0000_0001);
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  0, 32'hFFFF_FFFF);
    run_op(OP_MULHSU, 32'h0000_0002, 32'h8000_0000, 5'd6,  0, 32'h0000_0001);

    // Backpressure with a queued request, then same-cycle consume and accept
    start_op(OP_MUL, 32'h0000_0003, 32'h0000_0005, 5'd7);
    wait_result("bp_latency");
    in_valid = 1'b1; in_op = OP_MULHU; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_tag = 5'd9;
    for (int h = 0; h < 3; h++) begin
      #1;
      check("bp_ready", 64'(in_ready), 64'd0);
      check("bp_result", 64'(out_result), 64'h0F);
      check("bp_tag", 64'(out_tag), 64'd7);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_pass", 64'(in_ready), 64'd1);
    check("bp_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_valid_drop", 64'(out_valid), 64'd0);
    wait_result("b2b_latency");
    finish_op(0, 32'hFFFF_FFFE, 5'd9);

    // Flush in the third accumulate cycle
    start_op(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11);
    @(negedge clk); @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_idle", 64'(in_ready), 64'd1);
    watch_idle("flush_no_result", 10);

    // Flush in IDLE blocks an accept
    in_valid = 1'b1; in_op = OP_MUL; in_a = 32'd2; in_b = 32'd2; in_tag = 5'd12;
    flush = 1'b1;
    #1;
    check("flush_idle_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    watch_idle("flush_idle_no_accept", 10);

    // Reset in the middle of accumulation
    start_op(OP_MULH, 32'hDEAD_BEEF, 32'h1357_9BDF, 5'd13);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_result", 64'(out_result), 64'd0);
    check("mid_rst_tag", 64'(out_tag), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rel_ready", 64'(in_ready), 64'd1);
    watch_idle("rst_no_result", 10);

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_a   = pick_operand();
      r_b   = pick_operand();
      r_tag = TAG_W'($urandom);
      run_op(r_op, r_a, r_b, r_tag, $urandom_range(0, 3), model(r_op, r_a, r_b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
